// File: rtl/fu_alu_pipe.sv
// fu_alu_pipe: pipelined scalar ALU with valid/ready handshake, opaque tag and flush.
// Define ALU_FLAGS_EN to add out_zero/out_neg/out_ovf flags pipelined with the result.
module fu_alu_pipe #(
  parameter int DATA_W = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 5
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        aluop,
  input  logic [DATA_W-1:0] port_a,
  input  logic [DATA_W-1:0] port_b,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [TAG_W-1:0]  out_tag,
`ifdef ALU_FLAGS_EN
  output logic              out_zero,
  output logic              out_neg,
  output logic              out_ovf,
`endif
  output logic              out_illegal
);

  localparam int SH_W = $clog2(DATA_W);

  logic [SH_W-1:0]   w_shamt;
  logic [DATA_W-1:0] w_sum;
  logic [DATA_W-1:0] w_diff;
  logic [DATA_W-1:0] w_alu;
  logic              w_illegal;
  logic              w_accept;
  logic [STAGES-1:0] w_load;

  logic [STAGES-1:0] r_valid;
  logic [STAGES-1:0] r_illegal;
  logic [DATA_W-1:0] r_result [STAGES];
  logic [TAG_W-1:0]  r_tag    [STAGES];

  assign w_shamt = port_b[SH_W-1:0];
  assign w_sum   = port_a + port_b;
  assign w_diff  = port_a - port_b;

  always_comb begin
    w_alu     = '0;
    w_illegal = 1'b0;
    case (aluop)
      4'd0:    w_alu = port_a << w_shamt;
      4'd1:    w_alu = port_a >> w_shamt;
      4'd2:    w_alu = $signed(port_a) >>> w_shamt;
      4'd3:    w_alu = w_sum;
      4'd4:    w_alu = w_diff;
      4'd5:    w_alu = port_a & port_b;
      4'd6:    w_alu = port_a | port_b;
      4'd7:    w_alu = port_a ^ port_b;
      4'd10:   w_alu = {{(DATA_W-1){1'b0}}, $signed(port_a) < $signed(port_b)};
      4'd11:   w_alu = {{(DATA_W-1){1'b0}}, port_a < port_b};
      default: w_illegal = 1'b1;
    endcase
  end

  // A stage can load when it, or any stage downstream of it, is empty, or the
  // consumer is draining the last stage; this is ready propagated without bubbles.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      w_load[k] = out_ready;
      for (int j = k; j < STAGES; j++) begin
        if (!r_valid[j]) w_load[k] = 1'b1;
      end
    end
  end

  assign in_ready = w_load[0] & ~flush;
  assign w_accept = in_valid & in_ready;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_valid   <= '0;
      r_illegal <= '0;
      for (int k = 0; k < STAGES; k++) begin
        r_result[k] <= '0;
        r_tag[k]    <= '0;
      end
    end else begin
      if (flush) begin
        r_valid <= '0;
      end else begin
        if (w_load[0]) r_valid[0] <= w_accept;
        for (int k = 1; k < STAGES; k++) begin
          if (w_load[k]) r_valid[k] <= r_valid[k-1];
        end
      end
      if (w_accept) begin
        r_result[0]  <= w_alu;
        r_tag[0]     <= in_tag;
        r_illegal[0] <= w_illegal;
      end
      for (int k = 1; k < STAGES; k++) begin
        if (w_load[k] && r_valid[k-1]) begin
          r_result[k]  <= r_result[k-1];
          r_tag[k]     <= r_tag[k-1];
          r_illegal[k] <= r_illegal[k-1];
        end
      end
    end
  end

  assign out_valid   = r_valid[STAGES-1];
  assign out_result  = r_result[STAGES-1];
  assign out_tag     = r_tag[STAGES-1];
  assign out_illegal = r_illegal[STAGES-1];

`ifdef ALU_FLAGS_EN
  // Flag bit order: {zero, neg, ovf}
  logic [2:0] w_flags;
  logic       w_ovf;
  logic [2:0] r_flags [STAGES];

  always_comb begin
    w_ovf = 1'b0;
    if (aluop == 4'd3)
      w_ovf = (port_a[DATA_W-1] == port_b[DATA_W-1]) && (w_sum[DATA_W-1] != port_a[DATA_W-1]);
    else if (aluop == 4'd4)
      w_ovf = (port_a[DATA_W-1] != port_b[DATA_W-1]) && (w_diff[DATA_W-1] != port_a[DATA_W-1]);
  end

  assign w_flags = {w_alu == '0, w_alu[DATA_W-1], w_ovf};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int k = 0; k < STAGES; k++) r_flags[k] <= '0;
    end else begin
      if (w_accept) r_flags[0] <= w_flags;
      for (int k = 1; k < STAGES; k++) begin
        if (w_load[k] && r_valid[k-1]) r_flags[k] <= r_flags[k-1];
      end
    end
  end

  assign out_zero = r_flags[STAGES-1][2];
  assign out_neg  = r_flags[STAGES-1][1];
  assign out_ovf  = r_flags[STAGES-1][0];
`endif

endmodule

// File: tb/tb_fu_alu_pipe.sv
// Self-checking bench for fu_alu_pipe: directed scenarios plus a randomized stream
// checked against a queue-based reference model.
module tb_fu_alu_pipe;
  localparam int DATA_W = 32;
  localparam int STAGES = 2;
  localparam int TAG_W  = 5;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [3:0]        aluop = '0;
  logic [DATA_W-1:0] port_a = '0;
  logic [DATA_W-1:0] port_b = '0;
  logic [TAG_W-1:0]  in_tag = '0;
  logic              flush = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_result;
  logic [TAG_W-1:0]  out_tag;
  logic              out_illegal;
`ifdef ALU_FLAGS_EN
  logic              out_zero;
  logic              out_neg;
  logic              out_ovf;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  fu_alu_pipe #(.DATA_W(DATA_W), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .CLK(CLK), .RST(RST),
    .in_valid(in_valid), .in_ready(in_ready), .aluop(aluop),
    .port_a(port_a), .port_b(port_b), .in_tag(in_tag), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_tag(out_tag),
`ifdef ALU_FLAGS_EN
    .out_zero(out_zero), .out_neg(out_neg), .out_ovf(out_ovf),
`endif
    .out_illegal(out_illegal)
  );

  always #5 CLK = ~CLK;

  // Reference ALU: returns {illegal, result}
  function automatic logic [DATA_W:0] ref_alu(input logic [3:0] op,
                                              input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] r;
    logic ill;
    int sh;
    sh  = int'(b % DATA_W);
    r   = '0;
    ill = 1'b0;
    case (op)
      4'd0:    r = a << sh;
      4'd1:    r = a >> sh;
      4'd2:    r = $signed(a) >>> sh;
      4'd3:    r = a + b;
      4'd4:    r = a - b;
      4'd5:    r = a & b;
      4'd6:    r = a | b;
      4'd7:    r = a ^ b;
      4'd10:   r = ($signed(a) < $signed(b)) ? 1 : 0;
      4'd11:   r = (a < b) ? 1 : 0;
      default: ill = 1'b1;
    endcase
    return {ill, r};
  endfunction

  task automatic drive(input logic v, input logic [3:0] op, input logic [DATA_W-1:0] a,
                       input logic [DATA_W-1:0] b, input logic [TAG_W-1:0] tag);
    in_valid = v;
    aluop    = op;
    port_a   = a;
    port_b   = b;
    in_tag   = tag;
  endtask

  task automatic apply_reset();
    @(negedge CLK);
    drive(1'b0, 4'd0, '0, '0, '0);
    flush     = 1'b0;
    out_ready = 1'b0;
    RST       = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if ({out_valid, out_result, out_tag, out_illegal} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b r=%h t=%h i=%b, want all 0",
               out_valid, out_result, out_tag, out_illegal);
    end
    @(negedge CLK);
    RST = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got in_ready=%b out_valid=%b, want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_basic_add();
    apply_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK);
      if (c == 0) drive(1'b1, 4'd3, 32'd2, 32'd3, 5'd7);
      else        drive(1'b0, 4'd0, '0, '0, '0);
      #1;
      n_checks++;
      if (c == 0 && in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL add_in_ready: got %b want 1", in_ready);
      end else if (c == 1 && out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL add_early_valid: got out_valid=%b want 0 one cycle after handshake", out_valid);
      end else if (c == 2 && {out_valid, out_result, out_tag, out_illegal} !== {1'b1, 32'd5, 5'd7, 1'b0}) begin
        n_fail++;
        $display("FAIL add_result: got v=%b r=%0d t=%0d i=%b want v=1 r=5 t=7 i=0",
                 out_valid, out_result, out_tag, out_illegal);
      end else if (c == 3 && out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL add_dup: got out_valid=%b want 0 after single op", out_valid);
      end
    end
  endtask

  typedef struct {
    logic [3:0]        op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] r;
    logic              ill;
  } vec_t;

  task automatic test_op_sweep();
    vec_t v[13];
    v[0]  = '{4'd0,  32'h8,        32'h1,      32'h10,       1'b0};
    v[1]  = '{4'd1,  32'h8,        32'h1,      32'h4,        1'b0};
    v[2]  = '{4'd2,  32'hC0000000, 32'h1,      32'hE0000000, 1'b0};
    v[3]  = '{4'd4,  32'h6,        32'h2,      32'h4,        1'b0};
    v[4]  = '{4'd5,  32'h0000FFFF, 32'h0000F0E0, 32'h0000F0E0, 1'b0};
    v[5]  = '{4'd6,  32'h0000FFFF, 32'h0000F0E0, 32'h0000FFFF, 1'b0};
    v[6]  = '{4'd7,  32'h0000FFFF, 32'h0000F0E0, 32'h00000F1F, 1'b0};
    v[7]  = '{4'd10, 32'h0000F0E0, 32'h0000FFE0, 32'h1,        1'b0};
    v[8]  = '{4'd11, 32'hF000FFE0, 32'h0000F0E0, 32'h0,        1'b0};
    v[9]  = '{4'd0,  32'h8,        32'd33,     32'h10,       1'b0};
    v[10] = '{4'd9,  32'h5,        32'h5,      32'h0,        1'b1};
    v[11] = '{4'd3,  32'h1,        32'h1,      32'h2,        1'b0};
    v[12] = '{4'd10, 32'hFFFFFFFF, 32'h1,      32'h1,        1'b0};
    apply_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 13 + STAGES; i++) begin
      @(negedge CLK);
      if (i < 13) drive(1'b1, v[i].op, v[i].a, v[i].b, TAG_W'(i));
      else        drive(1'b0, 4'd0, '0, '0, '0);
      #1;
      if (i >= STAGES) begin
        n_checks++;
        if ({out_valid, out_result, out_tag, out_illegal} !==
            {1'b1, v[i-STAGES].r, TAG_W'(i-STAGES), v[i-STAGES].ill}) begin
          n_fail++;
          $display("FAIL sweep_op%0d: got v=%b r=%h t=%0d i=%b want v=1 r=%h t=%0d i=%b",
                   i-STAGES, out_valid, out_result, out_tag, out_illegal,
                   v[i-STAGES].r, i-STAGES, v[i-STAGES].ill);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int next_tag;
    int exp_out;
    int first_cyc;
    apply_reset();
    next_tag  = 1;
    exp_out   = 1;
    first_cyc = -1;
    for (int c = 0; c < 14; c++) begin
      @(negedge CLK);
      out_ready = (c >= 6);
      if (next_tag <= 4) drive(1'b1, 4'd3, 32'(next_tag), 32'd100, TAG_W'(next_tag));
      else               drive(1'b0, 4'd0, '0, '0, '0);
      #1;
      if (c >= 2 && c <= 5) begin
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_tag !== 5'd1 || out_result !== 32'd101) begin
          n_fail++;
          $display("FAIL bp_hold_c%0d: got in_ready=%b v=%b t=%0d r=%0d want 0/1/1/101",
                   c, in_ready, out_valid, out_tag, out_result);
        end
      end
      if (out_valid && out_ready) begin
        if (first_cyc < 0) first_cyc = c;
        n_checks++;
        if (out_tag !== TAG_W'(exp_out) || out_result !== 32'(exp_out + 100) ||
            c != first_cyc + exp_out - 1) begin
          n_fail++;
          $display("FAIL bp_drain: got t=%0d r=%0d at cycle %0d, want t=%0d r=%0d at cycle %0d",
                   out_tag, out_result, c, exp_out, exp_out + 100, first_cyc + exp_out - 1);
        end
        exp_out++;
      end
      if (in_valid && in_ready) next_tag++;
    end
    n_checks++;
    if (exp_out != 5 || next_tag != 5) begin
      n_fail++;
      $display("FAIL bp_count: delivered %0d accepted %0d, want 4 and 4", exp_out - 1, next_tag - 1);
    end
  endtask

  task automatic test_flush();
    apply_reset();
    for (int c = 0; c < 9; c++) begin
      @(negedge CLK);
      flush     = (c == 2);
      out_ready = (c >= 3);
      case (c)
        0:       drive(1'b1, 4'd3, 32'd1, 32'd1, 5'd10);
        1:       drive(1'b1, 4'd3, 32'd2, 32'd2, 5'd11);
        2:       drive(1'b1, 4'd3, 32'd3, 32'd3, 5'd12);
        3:       drive(1'b1, 4'd7, 32'hFF, 32'h0F, 5'd13);
        default: drive(1'b0, 4'd0, '0, '0, '0);
      endcase
      #1;
      n_checks++;
      if (c == 2 && (in_ready !== 1'b0 || out_valid !== 1'b1)) begin
        n_fail++;
        $display("FAIL flush_cycle: got in_ready=%b out_valid=%b want 0/1", in_ready, out_valid);
      end else if ((c == 3 || c == 4 || c >= 6) && out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL flush_stale_c%0d: got out_valid=%b tag=%0d want out_valid=0", c, out_valid, out_tag);
      end else if (c == 5 && {out_valid, out_tag, out_result} !== {1'b1, 5'd13, 32'hF0}) begin
        n_fail++;
        $display("FAIL flush_next_op: got v=%b t=%0d r=%h want v=1 t=13 r=f0", out_valid, out_tag, out_result);
      end
    end
    flush = 1'b0;
  endtask

  task automatic test_reset_midstream();
    apply_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      if (c < 2) drive(1'b1, 4'd12, 32'd5, 32'd5, TAG_W'(20 + c));
      else       drive(1'b0, 4'd0, '0, '0, '0);
    end
    #1;
    n_checks++;
    if (out_valid !== 1'b1 || out_illegal !== 1'b1 || out_tag !== 5'd20) begin
      n_fail++;
      $display("FAIL rst_pre: got v=%b i=%b t=%0d want 1/1/20", out_valid, out_illegal, out_tag);
    end
    #2 RST = 1'b1;
    #1;
    n_checks++;
    if ({out_valid, out_result, out_tag, out_illegal} !== '0) begin
      n_fail++;
      $display("FAIL rst_async: got v=%b r=%h t=%0d i=%b want all 0",
               out_valid, out_result, out_tag, out_illegal);
    end
    @(negedge CLK);
    RST       = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL rst_stale_c%0d: got out_valid=%b in_ready=%b want 0/1", c, out_valid, in_ready);
      end
    end
  endtask

  typedef struct {
    logic [DATA_W-1:0] r;
    logic [TAG_W-1:0]  tag;
    logic              ill;
    int                t_vis;
  } exp_t;

  task automatic test_random();
    exp_t q[$];
    exp_t e;
    logic [DATA_W:0] m;
    logic p_valid, p_ready, p_flush, p_ill;
    logic [DATA_W-1:0] p_res;
    logic [TAG_W-1:0]  p_tag;
    logic exp_ready, exp_valid;
    apply_reset();
    p_valid = 1'b0; p_ready = 1'b0; p_flush = 1'b0; p_ill = 1'b0; p_res = '0; p_tag = '0;
    for (int n = 0; n < 400; n++) begin
      @(negedge CLK);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 39) == 0);
      drive($urandom_range(0, 9) < 7, 4'($urandom_range(0, 15)), $urandom(),
            ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 40)) : $urandom(),
            TAG_W'($urandom()));
      #1;
      exp_ready = !flush && (out_ready || q.size() < STAGES);
      exp_valid = (q.size() > 0) && (n >= q[0].t_vis);
      n_checks++;
      if (in_ready !== exp_ready || out_valid !== exp_valid) begin
        n_fail++;
        $display("FAIL rand_handshake n=%0d: got in_ready=%b out_valid=%b want %b/%b",
                 n, in_ready, out_valid, exp_ready, exp_valid);
      end
      if (exp_valid) begin
        n_checks++;
        if (out_result !== q[0].r || out_tag !== q[0].tag || out_illegal !== q[0].ill) begin
          n_fail++;
          $display("FAIL rand_data n=%0d: got r=%h t=%0d i=%b want r=%h t=%0d i=%b",
                   n, out_result, out_tag, out_illegal, q[0].r, q[0].tag, q[0].ill);
        end
      end
      if (p_valid && !p_ready && !p_flush) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_result !== p_res || out_tag !== p_tag || out_illegal !== p_ill) begin
          n_fail++;
          $display("FAIL rand_hold n=%0d: got v=%b r=%h t=%0d i=%b want v=1 r=%h t=%0d i=%b",
                   n, out_valid, out_result, out_tag, out_illegal, p_res, p_tag, p_ill);
        end
      end
      p_valid = out_valid; p_ready = out_ready; p_flush = flush;
      p_res = out_result; p_tag = out_tag; p_ill = out_illegal;
      if (flush) begin
        q.delete();
      end else begin
        if (exp_valid && out_ready) void'(q.pop_front());
        if (in_valid && exp_ready) begin
          m       = ref_alu(aluop, port_a, port_b);
          e.r     = m[DATA_W-1:0];
          e.ill   = m[DATA_W];
          e.tag   = in_tag;
          e.t_vis = n + STAGES;
          q.push_back(e);
        end
      end
    end
    flush = 1'b0;
  endtask

`ifdef ALU_FLAGS_EN
  task automatic test_flags();
    logic [2:0] exp_f [3];
    exp_f[0] = 3'b010;
    exp_f[1] = 3'b100;
    exp_f[2] = 3'b010;
    apply_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 3 + STAGES; i++) begin
      @(negedge CLK);
      case (i)
        0:       drive(1'b1, 4'd3, 32'h7FFFFFFF, 32'h1, 5'd1);
        1:       drive(1'b1, 4'd4, 32'd5, 32'd5, 5'd2);
        2:       drive(1'b1, 4'd5, 32'h80000000, 32'hFFFFFFFF, 5'd3);
        default: drive(1'b0, 4'd0, '0, '0, '0);
      endcase
      #1;
      if (i == STAGES) begin
        n_checks++;
        if ({out_valid, out_result, out_zero, out_neg, out_ovf} !== {1'b1, 32'h80000000, 3'b011}) begin
          n_fail++;
          $display("FAIL flags_add_ovf: got v=%b r=%h z=%b n=%b o=%b want 1 80000000 0 1 1",
                   out_valid, out_result, out_zero, out_neg, out_ovf);
        end
      end else if (i > STAGES) begin
        n_checks++;
        if (out_valid !== 1'b1 || {out_zero, out_neg, out_ovf} !== exp_f[i-STAGES]) begin
          n_fail++;
          $display("FAIL flags_op%0d: got v=%b zno=%b%b%b want v=1 zno=%b",
                   i-STAGES, out_valid, out_zero, out_neg, out_ovf, exp_f[i-STAGES]);
        end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_add();
    test_op_sweep();
    test_backpressure();
    test_flush();
    test_reset_midstream();
`ifdef ALU_FLAGS_EN
    test_flags();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fu_alu_pipe.md
Name: fu_alu_pipe

Overview:
Pipelined, parametrised-width successor to the combinational scalar ALU functional unit. Accepts one op per cycle over a valid/ready handshake and carries a caller tag alongside the data. The result emerges after a configurable number of register stages, with full backpressure and a flush input. Sits between the issue stage and the writeback/result bus of the tensor-core scalar path.

Parameters:
DATA_W, 32, operand/result width in bits (power of two, >= 8)
STAGES, 2, number of register stages from input to output (>= 1)
TAG_W, 5, width of opaque tag carried with each op (e.g. destination reg)

Ports:
CLK  input  1  clock, rising edge
RST  input  1  asynchronous reset, active-high
in_valid  input  1  op present on inputs
in_ready  output  1  unit can accept op this cycle
aluop  input  4  operation code (encoding below)
port_a  input  DATA_W  operand A
port_b  input  DATA_W  operand B / shift amount
in_tag  input  TAG_W  tag travelling with op
flush  input  1  discard all in-flight ops
out_valid  output  1  result present
out_ready  input  1  consumer accepts result
out_result  output  DATA_W  result
out_tag  output  TAG_W  tag of result
out_illegal  output  1  op code was unassigned

Behaviour:
- aluop encoding: 0 SLL, 1 SRL, 2 SRA, 3 ADD, 4 SUB, 5 AND, 6 OR, 7 XOR, 10 SLT (signed), 11 SLTU; 8, 9, 12-15 unassigned.
- Shift amount = port_b[log2(DATA_W)-1:0]; upper bits ignored. SRA replicates port_a MSB.
- ADD/SUB wrap modulo 2^DATA_W. SLT/SLTU produce 1 or 0, zero-extended to DATA_W.
- Unassigned op: result 0, out_illegal=1 for that op. The op still occupies a slot and still completes.
- Result computed combinationally at input and captured into stage 0. Stages 1..STAGES-1 are pure delay registers holding {valid, result, tag, illegal}.
- Stage k loads when its valid is 0 or it is advancing. The last stage advances when out_ready=1.
- in_ready = (stage 0 empty OR stage 0 advancing) AND NOT flush. Ready propagates combinationally back through the stages, so no bubbles are inserted under backpressure.
- Transfer occurs only when valid and ready are both high on a rising edge. out_result/out_tag/out_illegal must hold stable while out_valid=1 and out_ready=0.
- Latency: STAGES cycles from input handshake to out_valid with out_ready held high. Throughput: 1 op/cycle.
- Full pipe (all STAGES valid) with out_ready=0: in_ready=0. If out_ready=1 in the same cycle, in_ready=1 and a simultaneous input and output transfer occurs.
- flush=1: all stage valids clear on the next edge. The op presented that cycle is not accepted. out_valid remains as registered during the flush cycle, and no output transfer counts.
- Reset (asynchronous, any time including mid-stream): all valids, results, tags and illegal bits reset to 0. Outputs out_valid=0, out_result=0, out_tag=0, out_illegal=0. in_ready=1 once RST deasserts.

Optional Feature:
ALU_FLAGS_EN
- When defined, adds outputs out_zero (result==0), out_neg (result MSB) and out_ovf (signed overflow on ADD/SUB, 0 for all other ops). The flags are pipelined with the result, reset to 0, and obey the same hold rules.
- When undefined, the flag ports and their registers are absent; all other behaviour is identical.

Test Plan:
- DATA_W=32, STAGES=2, out_ready=1: ADD a=2, b=3, tag=7 -> out_valid exactly 2 cycles after handshake, out_result=5, out_tag=7, out_illegal=0.
- Per-op sweep: SLL 8<<1=16, SRL 8>>1=4, SRA 0xC0000000>>1=0xE0000000, SUB 6-2=4, AND/OR/XOR of 0x0000FFFF,0x0000F0E0 = 0x0000F0E0/0x0000FFFF/0x00000F1F, SLT 0xF0E0<0xFFE0=1, SLTU 0xF000FFE0<0xF0E0=0, shift b=33 behaves as 1.
- Backpressure: stream 4 back-to-back ADDs with tags 1-4, out_ready=0 -> in_ready drops after 2 accepted. Output holds tag 1 stable; raise out_ready -> tags 1,2,3,4 delivered in order, one per cycle, none lost or duplicated.
- Flush with 2 ops in flight, in_valid=1 -> in_ready=0 that cycle, out_valid=0 next cycle, flushed tags never appear, next op after flush has normal latency.
- aluop=9, a=5, b=5 -> out_result=0, out_illegal=1. The following ADD returns out_illegal=0. Assert RST mid-stream -> all outputs 0 immediately, no stale op emerges afterwards.
- ALU_FLAGS_EN, DATA_W=8: ADD 0x7F+0x01 -> result 0x80, out_ovf=1, out_neg=1, out_zero=0. SUB 5-5 -> out_zero=1, out_ovf=0.
